// File: rtl/keypad_pkg.sv
// Shared keypad definitions: control key codes, operand-entry states and BCD conversion.
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } entry_state_t;

  // Three packed BCD digits to binary; 999 is the largest result.
  function automatic logic [9:0] bcd3_to_bin(input logic [11:0] bcd);
    return 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/digit_decoder.sv
// Classifies a raw keypad code as a decimal digit and yields its value.
module digit_decoder (
  input  logic [3:0] keycode,
  output logic       isdig,
  output logic [3:0] digitCode
);

  always_comb begin
    isdig     = (keycode <= 4'd9);
    digitCode = isdig ? keycode : '0;
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry: collects up to three decimal digits with backspace/clear,
// commits the binary value on ENTER and holds it until the consumer accepts it.
module operand_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned VAL_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keystrobe,
  input  logic [3:0]       keycode,
  input  logic             value_ready,
  output logic [VAL_W-1:0] value,
  output logic             value_valid,
  output logic [11:0]      disp_bcd,
  output logic [1:0]       digit_count,
  output logic             err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  entry_state_t     state_q, state_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             err_q, err_d;
  logic             ks_q, ks_d;

  logic             key_evt;
  logic             isdig;
  logic [3:0]       digit_code;

  digit_decoder u_digit_decoder (
    .keycode   (keycode),
    .isdig     (isdig),
    .digitCode (digit_code)
  );

  assign key_evt = keystrobe & ~ks_q;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    err_d   = 1'b0;
    ks_d    = keystrobe;

    case (state_q)
      IDLE, ENTRY: begin
        if (key_evt) begin
          if (isdig) begin
            if (cnt_q == MAX_CNT) begin
              err_d = 1'b1;
            end else begin
              bcd_d   = {bcd_q[7:0], digit_code};
              cnt_d   = cnt_q + 2'd1;
              state_d = ENTRY;
            end
          end else begin
            case (keycode)
              KEY_ENTER: begin
                if (state_q == ENTRY) begin
                  value_d = VAL_W'(bcd3_to_bin(bcd_q));
                  state_d = HOLD;
                end else begin
                  err_d = 1'b1;
                end
              end
              KEY_BKSP: begin
                if (cnt_q == 2'd0) begin
                  err_d = 1'b1;
                end else begin
                  bcd_d = {4'h0, bcd_q[11:4]};
                  cnt_d = cnt_q - 2'd1;
                  if (cnt_q == 2'd1) state_d = IDLE;
                end
              end
              KEY_CLR: begin
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
              end
              default: ;
            endcase
          end
        end
      end
      HOLD: begin
        // Keys are deliberately dropped here, even one coinciding with the handshake.
        if (value_ready) begin
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
      ks_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      err_q   <= err_d;
      ks_q    <= ks_d;
    end
  end

  assign value       = value_q;
  assign value_valid = (state_q == HOLD);
  assign disp_bcd    = bcd_q;
  assign digit_count = cnt_q;
  assign err         = err_q;

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 3, the maximum decimal digits per operand (this spec fixes 3).
REQ-002 The block SHALL have parameter VAL_W, default 10, the width of the committed binary operand.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 keystrobe  input  1  level from keypad scanner; high while a key is held.
REQ-006 keycode  input  4  raw key code, valid while keystrobe is high.
REQ-007 value_ready  input  1  consumer accepts the committed operand.
REQ-008 value  output  VAL_W  committed binary operand.
REQ-009 value_valid  output  1  committed operand available.
REQ-010 disp_bcd  output  12  live BCD entry; most recent digit in [3:0].
REQ-011 digit_count  output  2  number of digits entered (0..3).
REQ-012 err  output  1  one-cycle pulse on a rejected key.

Function
REQ-013 A key event SHALL be a rising edge of keystrobe, meaning keystrobe is high this cycle and the registered keystrobe is low; a held key SHALL produce exactly one event.
REQ-014 Codes 0-9 SHALL be classified through the digit_decoder sub-module (isdig, digitCode); 10 SHALL be ENTER, 11 BKSP and 12 CLR; 13-15 SHALL be ignored without err.
REQ-015 The FSM states SHALL be IDLE (0 digits), ENTRY (1..3 digits) and HOLD (value_valid high).
REQ-016 A digit in IDLE or ENTRY with count < 3 SHALL shift disp_bcd left by 4, insert the digit at [3:0], increment the count and leave or stay in ENTRY.
REQ-017 A digit with count = 3 SHALL leave state and digits unchanged and pulse err.
REQ-018 BKSP SHALL shift disp_bcd right by 4 (zero fill) and decrement the count; reaching count 0 SHALL go to IDLE; BKSP in IDLE SHALL pulse err.
REQ-019 CLR in IDLE or ENTRY SHALL zero disp_bcd and the count and go to IDLE, without err.
REQ-020 ENTER in ENTRY SHALL register value = d2*100 + d1*10 + d0 (maximum 999, which fits VAL_W) and go to HOLD.
REQ-021 ENTER in IDLE SHALL pulse err.
REQ-022 value_valid SHALL be high exactly while in HOLD, starting the cycle after the ENTER event.
REQ-023 value SHALL remain stable while value_valid is high.
REQ-024 In HOLD, value_valid && value_ready at a rising edge SHALL complete the handshake, zero the digits and count, and go to IDLE.
REQ-025 In HOLD, all key events SHALL be ignored without err, including an event coincident with the handshake.
REQ-026 Latency SHALL be one cycle: the effect of an event sampled at edge N is visible after edge N.
REQ-027 value SHALL hold its last committed value outside HOLD.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, value=0, value_valid=0, disp_bcd=0, digit_count=0, err=0 and the keystrobe history register to 0, including mid-entry and mid-handshake.
REQ-029 A key still held when rst deasserts SHALL produce an event on the first clock edge after deassertion.

Structure
REQ-030 The shared package keypad_pkg SHALL hold the KEY_ENTER=4'hA, KEY_BKSP=4'hB and KEY_CLR=4'hC constants and the entry_state_t enum {IDLE, ENTRY, HOLD}.
REQ-031 The block SHALL instance one digit_decoder sub-module for digit classification; no other sub-modules.

Verification
REQ-032 Keys 4, 0, 7 then ENTER, value_ready low -> value=407 and value_valid=1, held for 5 cycles; value_ready=1 for 1 cycle -> IDLE, digit_count=0.
REQ-033 Keys 1, 2, 3, 5 -> err pulses once on the 5; disp_bcd=12'h123; ENTER -> value=123.
REQ-034 Keys 9, 8, BKSP, 6, ENTER -> disp_bcd=12'h096 before ENTER, value=96; BKSP in IDLE -> err=1 for one cycle.
REQ-035 keystrobe held high 10 cycles with keycode 5 -> digit_count=1; keys 13, 14, 15 -> no state change, err=0.
REQ-036 rst asserted mid-entry (2 digits) and in HOLD (value_valid=1) -> all outputs 0 with no clock edge; ENTER in IDLE -> err pulse, value_valid stays 0.
REQ-037 In HOLD, key 3 edge coincident with value_ready=1 -> IDLE with digit_count=0, key ignored.
